pixel_writer: RTL

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_writer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pixel_writer.sv
// pixel_writer: lines up iterator requests with the solver read data two cycles
// later, turns iteration counts into colours and streams {address, colour}
// pairs to the framebuffer through a small FIFO with early stall.
module pixel_writer #(
    parameter int NUM_SOLVERS = 1,
    parameter int WIDTH       = 99,
    parameter int HEIGHT      = 66,
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_ITER    = 255,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic [5:0]            solver_id,
    input  logic [18:0]           solver_addr,
    input  logic                  end_stream,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  stall,
    output logic [18:0]           fb_addr,
    output logic [7:0]            fb_data,
    output logic                  fb_we,
    input  logic                  fb_ready,
    output logic                  frame_done,
    output logic                  addr_err
);

    localparam int                PTR_W        = $clog2(FIFO_DEPTH);
    localparam int                CNT_W        = PTR_W + 1;
    localparam logic [18:0]       FRAME_PIXELS = 19'(WIDTH * HEIGHT);
    localparam logic [CNT_W-1:0]  STALL_LEVEL  = CNT_W'(FIFO_DEPTH - 3);
    localparam logic [DATA_WIDTH-1:0] SET_LEVEL = DATA_WIDTH'(MAX_ITER);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    // One iterator request travelling down the alignment pipeline.
    typedef struct packed {
        logic        valid;
        logic [5:0]  id;
        logic [18:0] addr;
        logic        last;
    } req_t;

    // One pending framebuffer write.
    typedef struct packed {
        logic [18:0] addr;
        logic [7:0]  colour;
    } entry_t;

    state_e           state_q, state_d;
    req_t             stage1_q, stage2_q;
    entry_t           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stall_q;
    logic             addr_err_q;

    logic [18:0]      pixel_idx;
    logic [7:0]       colour;
    logic             in_range;
    logic             beat;
    logic             push;
    logic             drop;
    logic             pop;
    logic             empty;

    // Datapath for the aligned beat: linear index, range test and colour.
    assign pixel_idx = stage2_q.addr * 19'(NUM_SOLVERS) + 19'(stage2_q.id);
    assign in_range  = pixel_idx < FRAME_PIXELS;
    assign colour    = (rd_data >= SET_LEVEL) ? 8'h00 : (rd_data[7:0] | 8'h01);

    // Only beats that arrive while streaming reach the FIFO; late ones in DRAIN are ignored.
    assign beat  = stage2_q.valid && (state_q == STREAM);
    assign push  = beat && in_range;
    assign drop  = beat && !in_range;
    assign empty = (count_q == '0);
    assign pop   = !empty && fb_ready;

    assign fb_we      = !empty;
    assign fb_addr    = empty ? 19'd0 : mem_q[rd_ptr_q].addr;
    assign fb_data    = empty ? 8'd0  : mem_q[rd_ptr_q].colour;
    assign stall      = stall_q;
    assign frame_done = (state_q == DONE);
    assign addr_err   = addr_err_q;

    // Two-stage request pipeline that advances every cycle so it meets rd_data.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: state registers use non-blocking assignment so every flop samples
        // pre-edge values; blocking here would collapse the two stages into one.
        if (!reset) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= '{valid: en, id: solver_id, addr: solver_addr, last: end_stream};
            stage2_q <= stage1_q;
        end
    end

    // FIFO occupancy after this cycle's push and pop; both together cancel out.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers, occupancy, registered stall and sticky range error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            // Threshold leaves room for two beats in flight plus one cycle of stall latency.
            stall_q <= (count_d >= STALL_LEVEL);
            if (drop) addr_err_q <= 1'b1;
        end
    end

    // FIFO storage written on push.
    always_ff @(posedge clock) begin
        // NOTE: the storage array has no reset; pointers and count are cleared,
        // and the outputs are forced to zero whenever the FIFO is empty.
        if (push) mem_q[wr_ptr_q] <= '{addr: pixel_idx, colour: colour};
    end

    // Frame state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Frame sequencing: start on first beat, drain after the last one, pulse done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = STREAM;
            STREAM:  if (beat && stage2_q.last) state_d = DRAIN;
            DRAIN:   if (empty) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule
